// File: rtl/tt_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : tt_sweep_ctrl_if
// Description : Request, stimulus and result bundle of the truth-table sweeper.
// Revision    : 1.0 - initial release
// ============================================================================
interface tt_sweep_ctrl_if;
    logic        start;
    logic        abort;
    logic [3:0]  dut_in;
    logic        f_in;
    logic        f1_in;
    logic        busy;
    logic        done;
    logic [15:0] f_table;
    logic [15:0] f1_table;
    logic [4:0]  mismatch_cnt;
    logic [3:0]  first_fail_idx;
    logic        fail_seen;
    logic        pass;

    // Requester and function-block side.
    modport master (
        output start, abort, f_in, f1_in,
        input  dut_in, busy, done, f_table, f1_table,
        input  mismatch_cnt, first_fail_idx, fail_seen, pass
    );

    // Sweep controller side.
    modport slave (
        input  start, abort, f_in, f1_in,
        output dut_in, busy, done, f_table, f1_table,
        output mismatch_cnt, first_fail_idx, fail_seen, pass
    );
endinterface
`default_nettype wire

// File: rtl/tt_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tt_sweep_ctrl
// Description : Exhaustive 16-vector sweep of a 4-in/2-out block with capture
//               of both truth tables and comparison against expected tables.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_sweep_ctrl #(
    parameter int unsigned SETTLE = 1,
    parameter logic [15:0] EXP_F  = 16'h0000,
    parameter logic [15:0] EXP_F1 = 16'h0000
) (
    input  logic           clk,
    input  logic           rst,
    tt_sweep_ctrl_if.slave bus
);

    localparam logic [3:0]  c_SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [3:0]  c_LAST_IDX    = 4'd15;
    localparam logic [15:0] c_EXP_F       = EXP_F;
    localparam logic [15:0] c_EXP_F1      = EXP_F1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_idx;
    logic [3:0]  r_cnt;
    logic [3:0]  r_dut_in;
    logic [15:0] r_f_table;
    logic [15:0] r_f1_table;
    logic [4:0]  r_mismatch_cnt;
    logic [3:0]  r_first_fail_idx;
    logic        r_fail_seen;

    logic        w_accept;
    logic        w_capture;
    logic        w_vec_miss;
    logic [3:0]  w_idx_inc;

    assign w_accept   = (r_state == S_IDLE) && bus.start && !bus.abort;
    assign w_capture  = (r_state == S_SAMPLE) && !bus.abort;
    assign w_vec_miss = (bus.f_in != c_EXP_F[r_idx]) || (bus.f1_in != c_EXP_F1[r_idx]);
    assign w_idx_inc  = r_idx + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == c_SETTLE_LAST) begin
                    w_state_nxt = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_idx == c_LAST_IDX) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_SETTLE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx            <= 4'd0;
            r_cnt            <= 4'd0;
            r_dut_in         <= 4'd0;
            r_f_table        <= 16'd0;
            r_f1_table       <= 16'd0;
            r_mismatch_cnt   <= 5'd0;
            r_first_fail_idx <= 4'd0;
            r_fail_seen      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_idx            <= 4'd0;
                r_cnt            <= 4'd0;
                r_dut_in         <= 4'd0;
                r_f_table        <= 16'd0;
                r_f1_table       <= 16'd0;
                r_mismatch_cnt   <= 5'd0;
                r_first_fail_idx <= 4'd0;
                r_fail_seen      <= 1'b0;
            end else if (bus.abort && ((r_state == S_SETTLE) || (r_state == S_SAMPLE))) begin
                // Partial results stay visible; only the stimulus is released.
                r_dut_in <= 4'd0;
            end else if (r_state == S_SETTLE) begin
                r_cnt <= r_cnt + 4'd1;
            end else if (w_capture) begin
                r_f_table[r_idx]  <= bus.f_in;
                r_f1_table[r_idx] <= bus.f1_in;
                if (w_vec_miss) begin
                    r_mismatch_cnt <= r_mismatch_cnt + 5'd1;
                    if (!r_fail_seen) begin
                        r_fail_seen      <= 1'b1;
                        r_first_fail_idx <= r_idx;
                    end
                end
                if (r_idx == c_LAST_IDX) begin
                    r_dut_in <= 4'd0;
                end else begin
                    r_idx    <= w_idx_inc;
                    r_cnt    <= 4'd0;
                    r_dut_in <= w_idx_inc;
                end
            end
        end
    end

    assign bus.dut_in         = r_dut_in;
    assign bus.busy           = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
    assign bus.done           = (r_state == S_DONE);
    assign bus.f_table        = r_f_table;
    assign bus.f1_table       = r_f1_table;
    assign bus.mismatch_cnt   = r_mismatch_cnt;
    assign bus.first_fail_idx = r_first_fail_idx;
    assign bus.fail_seen      = r_fail_seen;
    assign bus.pass           = (r_mismatch_cnt == 5'd0);

endmodule
`default_nettype wire

// File: tb/tb_tt_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt_sweep_ctrl
// Description : Directed bench for tt_sweep_ctrl with SETTLE=1 and SETTLE=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_sweep_ctrl;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   mode;
    int   done_cnt1;
    int   done_cnt2;

    tt_sweep_ctrl_if bus1 ();
    tt_sweep_ctrl_if bus2 ();

    tt_sweep_ctrl #(.SETTLE(1), .EXP_F(16'h6996), .EXP_F1(16'h8000)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    tt_sweep_ctrl #(.SETTLE(3), .EXP_F(16'h6996), .EXP_F1(16'h8000)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Function-block model: mode 1 sticks f1 at 0, mode 2 inverts f.
    always_comb begin
        bus1.f_in  = (^bus1.dut_in) ^ (mode == 2);
        bus1.f1_in = (mode == 1) ? 1'b0 : (&bus1.dut_in);
        bus2.f_in  = ^bus2.dut_in;
        bus2.f1_in = &bus2.dut_in;
    end

    always @(negedge clk) begin
        if (bus1.done === 1'b1) done_cnt1++;
        if (bus2.done === 1'b1) done_cnt2++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_results(input string tag, input logic [15:0] ft, input logic [15:0] f1t,
                                 input logic [4:0] mm, input logic fs, input logic [3:0] ffi,
                                 input logic ps);
        check({tag, "_f_table"}, 32'(bus1.f_table), 32'(ft));
        check({tag, "_f1_table"}, 32'(bus1.f1_table), 32'(f1t));
        check({tag, "_mismatch"}, 32'(bus1.mismatch_cnt), 32'(mm));
        check({tag, "_fail_seen"}, 32'(bus1.fail_seen), 32'(fs));
        check({tag, "_first_fail"}, 32'(bus1.first_fail_idx), 32'(ffi));
        check({tag, "_pass"}, 32'(bus1.pass), 32'(ps));
    endtask

    // Full SETTLE=1 sweep from acceptance (edge 0) to edge 33; sa/sb are edges
    // at which a stray start is presented.
    task automatic sweep1(input int sa, input int sb);
        @(negedge clk);
        bus1.start = 1'b1;
        @(posedge clk);
        #1 bus1.start = 1'b0;
        check("acc_busy", 32'(bus1.busy), 32'd1);
        check("acc_dut_in", 32'(bus1.dut_in), 32'd0);
        check("acc_f_clr", 32'(bus1.f_table), 32'd0);
        check("acc_mm_clr", 32'(bus1.mismatch_cnt), 32'd0);
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            bus1.start = (k == sa) || (k == sb);
            @(posedge clk);
            #1 bus1.start = 1'b0;
            if (k == 31) check("done_early", 32'(bus1.done), 32'd0);
        end
        check("done_e32", 32'(bus1.done), 32'd1);
        check("busy_e32", 32'(bus1.busy), 32'd0);
        check("dut_in_e32", 32'(bus1.dut_in), 32'd0);
        @(posedge clk);
        #1 check("done_e33", 32'(bus1.done), 32'd0);
    endtask

    int d0;

    initial begin
        errors = 0; checks = 0; mode = 0; done_cnt1 = 0; done_cnt2 = 0;
        rst = 1'b1;
        bus1.start = 1'b0; bus1.abort = 1'b0;
        bus2.start = 1'b0; bus2.abort = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_dut_in", 32'(bus1.dut_in), 32'd0);
        check("rst_busy", 32'(bus1.busy), 32'd0);
        check("rst_done", 32'(bus1.done), 32'd0);
        check_results("rst", 16'h0000, 16'h0000, 5'd0, 1'b0, 4'd0, 1'b1);

        // Good block.
        d0 = done_cnt1;
        sweep1(-1, -1);
        check("s1_done_count", 32'(done_cnt1 - d0), 32'd1);
        check_results("s1", 16'h6996, 16'h8000, 5'd0, 1'b0, 4'd0, 1'b1);
        repeat (3) @(posedge clk);
        #1 check("s1_hold_f", 32'(bus1.f_table), 32'h6996);

        // f1 stuck at 0.
        mode = 1;
        sweep1(-1, -1);
        check_results("stuck", 16'h6996, 16'h0000, 5'd1, 1'b1, 4'd15, 1'b0);

        // f inverted.
        mode = 2;
        sweep1(-1, -1);
        check_results("inv", 16'h9669, 16'h8000, 5'd16, 1'b1, 4'd0, 1'b0);

        // Stray starts during a sweep.
        mode = 0;
        d0 = done_cnt1;
        sweep1(5, 20);
        repeat (40) @(posedge clk);
        #1 check("restart_done_count", 32'(done_cnt1 - d0), 32'd1);
        check_results("restart", 16'h6996, 16'h8000, 5'd0, 1'b0, 4'd0, 1'b1);

        // Abort sampled at edge 10 (SAMPLE of vector 4).
        d0 = done_cnt1;
        @(negedge clk);
        bus1.start = 1'b1;
        @(posedge clk);
        #1 bus1.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus1.abort = 1'b1;
        @(posedge clk);
        #1 bus1.abort = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", 32'(bus1.busy), 32'd0);
        check("abort_dut_in", 32'(bus1.dut_in), 32'd0);
        check("abort_f_lo", 32'(bus1.f_table[3:0]), 32'h6);
        check("abort_f1_lo", 32'(bus1.f1_table[3:0]), 32'h0);
        repeat (40) @(posedge clk);
        #1 check("abort_no_done", 32'(done_cnt1 - d0), 32'd0);
        sweep1(-1, -1);
        check("abort_rerun_count", 32'(done_cnt1 - d0), 32'd1);
        check_results("rerun", 16'h6996, 16'h8000, 5'd0, 1'b0, 4'd0, 1'b1);

        // Reset mid-sweep at edge 10.
        d0 = done_cnt1;
        @(negedge clk);
        bus1.start = 1'b1;
        @(posedge clk);
        #1 bus1.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("mrst_busy", 32'(bus1.busy), 32'd0);
        check("mrst_dut_in", 32'(bus1.dut_in), 32'd0);
        check("mrst_done", 32'(bus1.done), 32'd0);
        check_results("mrst", 16'h0000, 16'h0000, 5'd0, 1'b0, 4'd0, 1'b1);
        repeat (40) @(posedge clk);
        #1 check("mrst_no_done", 32'(done_cnt1 - d0), 32'd0);

        // SETTLE=3: every vector held for 4 cycles, done after edge 64.
        d0 = done_cnt2;
        @(negedge clk);
        bus2.start = 1'b1;
        @(posedge clk);
        #1 bus2.start = 1'b0;
        for (int k = 0; k < 64; k++) begin
            check("s3_dut_in", 32'(bus2.dut_in), 32'(k / 4));
            check("s3_busy", 32'(bus2.busy), 32'd1);
            @(posedge clk);
            #1;
        end
        check("s3_done", 32'(bus2.done), 32'd1);
        check("s3_dut_in_end", 32'(bus2.dut_in), 32'd0);
        @(posedge clk);
        #1 check("s3_done_count", 32'(done_cnt2 - d0), 32'd1);
        check("s3_f_table", 32'(bus2.f_table), 32'h6996);
        check("s3_f1_table", 32'(bus2.f1_table), 32'h8000);
        check("s3_mismatch", 32'(bus2.mismatch_cnt), 32'd0);
        check("s3_pass", 32'(bus2.pass), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tt_sweep_ctrl.md
# tt_sweep_ctrl

Self-test sequencer for the team's 4-input, 2-output combinational function blocks (inputs a, b, c, d; outputs f, f1). On a start request it drives all 16 input combinations in binary count order and holds each one for a programmable settle time. It then samples both outputs into 16-bit truth-table registers and compares them against parameterised expected tables. It replaces hand-written exhaustive stimulus with an on-chip sweep and produces pass/fail status.

## Interface
- SETTLE, 1: cycles each vector is held before sampling; legal range 1..15.
- EXP_F, 16'h0000: expected f truth table; bit i is f for input vector i.
- EXP_F1, 16'h0000: expected f1 truth table; bit i is f1 for vector i.

- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  sweep request; sampled only in IDLE.
- abort  input  1  cancels an active sweep.
- dut_in  output  4  vector to the function block: [3]=a, [2]=b, [1]=c, [0]=d.
- f_in  input  1  f output of the function block.
- f1_in  input  1  f1 output of the function block.
- busy  output  1  high while the sweep runs (states SETTLE and SAMPLE).
- done  output  1  one-cycle pulse when the sweep completes.
- f_table  output  16  captured f values; bit i is the value for vector i.
- f1_table  output  16  captured f1 values.
- mismatch_cnt  output  5  number of vectors, 0..16, where f or f1 differed from expected.
- first_fail_idx  output  4  first failing vector; valid only when fail_seen=1.
- fail_seen  output  1  set on the first mismatch.
- pass  output  1  equals (mismatch_cnt==0); meaningful from done until the next start.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE. Vector index idx is 4 bits; a settle counter is 4 bits. dut_in is registered and equals idx while busy, and 0 otherwise.
- IDLE:
  - start=1 and abort=0 → go to SETTLE.
  - On that transition: idx=0, counter=0, f_table=0, f1_table=0, mismatch_cnt=0, fail_seen=0, first_fail_idx=0.
- SETTLE:
  - Counter increments each cycle.
  - When counter==SETTLE-1, go to SAMPLE.
- SAMPLE (one cycle):
  - f_table[idx]<=f_in and f1_table[idx]<=f1_in.
  - If f_in!=EXP_F[idx] or f1_in!=EXP_F1[idx]: mismatch_cnt increments by 1 per vector, even when both outputs differ.
  - On such a mismatch, if fail_seen=0: fail_seen<=1 and first_fail_idx<=idx.
  - If idx==15, go to DONE. Otherwise idx<=idx+1, counter<=0, and return to SETTLE.
  - idx never wraps inside a sweep.
- DONE: done=1 for this single cycle, then go to IDLE unconditionally.
- start while busy or in DONE is ignored; no queuing.
- abort=1 in SETTLE or SAMPLE:
  - Next state is IDLE and dut_in returns to 0.
  - No done pulse is generated.
  - Tables and counters keep their partial contents.
  - An aborted SAMPLE cycle does not capture.
- abort in IDLE or DONE has no effect, except that it blocks a simultaneous start in IDLE (abort wins).
- Results (tables, mismatch_cnt, first_fail_idx, fail_seen, pass) hold their values until the next accepted start.

## Timing
- Reset: state=IDLE and every output is 0, including dut_in, busy, done and all tables. pass=1 after reset, because it is derived from mismatch_cnt=0. Reset applied mid-sweep has the same effect and no done pulse is generated.
- Let edge 0 be the edge that accepts start.
  - dut_in=0 and busy=1 from edge 0.
  - Vector i is presented from edge i·(SETTLE+1).
  - Vector i is sampled at edge (i+1)·(SETTLE+1).
  - Each vector is held for exactly SETTLE+1 cycles.
- done is high in the cycle after edge 16·(SETTLE+1). For SETTLE=1 that is edge 32.
- busy is low in that DONE cycle. The earliest next start is accepted one cycle later, in IDLE.
- Combinational path from dut_in through the function block to f_in/f1_in must settle within SETTLE+1 cycles (SETTLE cycles in SETTLE plus the SAMPLE cycle).

## Test plan
- SETTLE=1, EXP_F=16'h6996, EXP_F1=16'h8000, bench model f=a^b^c^d and f1=a&b&c&d, single start → done pulse after edge 32, f_table=16'h6996, f1_table=16'h8000, mismatch_cnt=0, pass=1, fail_seen=0, dut_in=0 afterwards.
- Same setup but the model drives f1 stuck at 0 → f1_table=16'h0000, mismatch_cnt=1, fail_seen=1, first_fail_idx=15, pass=0.
- Model inverts f (f=~(a^b^c^d)) → mismatch_cnt=16, first_fail_idx=0, f_table=16'h9669.
- start pulsed again at edges 5 and 20 during a sweep → exactly one done, at edge 32, and results identical to the first scenario.
- abort at edge 10 → busy=0 and dut_in=0 from edge 11, no done, and bits 0..3 of f_table captured. A new start then runs a full 32-edge sweep with the tables cleared at acceptance. A separate case asserts rst at edge 10 → all outputs 0 and no done.
- SETTLE=3 → each dut_in value is held 4 cycles, done after edge 64, and the tables match the first scenario.
